mc_mem_responder: RTL

Pipelined multicycle main-memory responder serving the cache miss path. Sits behind the instruction/data cache arbitration: accepts one word request per cycle on the shared `addr`/`enable`/`wr` bus and returns read data exactly LATENCY cycles later with a `data_valid` strobe. Block fills of eight back-to-back reads therefore stream out one word per cycle. Writes complete in a single cycle with no response.

---
 rtl/mc_mem_responder.sv | 64 ++++++
 1 files changed

// File: rtl/mc_mem_responder.sv
// Pipelined multicycle main-memory responder for the cache miss path.
// Ports: clk, rst_n (async, active-low), addr, data_in, enable, wr -> data_out, data_valid.
module mc_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int WORDS_LOG2 = 15,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  input  logic              enable,
  input  logic              wr,
  output logic [15:0]       data_out,
  output logic              data_valid
);

  localparam int WORDS = 1 << WORDS_LOG2;

  logic [15:0]           mem_q [WORDS];
  logic [WORDS_LOG2-1:0] idx;
  logic                  mem_we;
  logic                  vld_d;
  logic [15:0]           dat_d;
  logic [LATENCY-1:0]    vld_q;
  logic [15:0]           dat_q [LATENCY];
  logic                  unused_addr;

  assign idx         = addr[WORDS_LOG2:1];
  assign unused_addr = ^addr;

  assign mem_we = enable & wr & rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= data_in;
    end
  end

  always_comb begin
    vld_d = enable & ~wr;
    dat_d = vld_d ? mem_q[idx] : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= 16'h0000;
      end
    end else begin
      vld_q[0] <= vld_d;
      dat_q[0] <= dat_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = data_valid ? dat_q[LATENCY-1] : 16'h0000;

endmodule
